pipe_hazard_unit: RTL

Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. It sits beside the ID stage and drives the IF/ID hold, the ID/EX bubble insert and the operand forwarding muxes. It tracks every in-flight instruction after ID in an internal shift register of DEPTH entries, so the stage count is generic rather than fixed. It adds load-use stalls, branch/jump flush and whole-pipeline freeze, none of which the current datapath has.

---
 rtl/pipe_hazard_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// ----------------
// Hazard, forwarding and flush controller for the in-order pipeline. It
// sits beside ID and tracks every instruction in flight after ID in a
// DEPTH-entry shift register (entry 0 = EX ... entry DEPTH-1 = WB).
// From that state and the ID-stage operands it produces, combinationally:
// the operand forwarding selects and data, the load-use stall with its
// ID/EX bubble, and the flush for a taken branch or jump.
//
// Parameters:
//   XLEN             data width
//   DEPTH            tracked stages after ID (2..6)
//   LOAD_READY_STAGE first entry index at which load data is valid (1..DEPTH-1)
//   FWD_W            width of the forward selects (derived)
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_valid_i                      ID holds a real instruction
//   id_rs1_i/id_rs2_i               source register addresses
//   id_rs1_used_i/id_rs2_used_i     source is actually read
//   id_rd_i, id_reg_we_i            destination and its write enable
//   id_is_load_i                    ID instruction is a load
//   rf_rs1_data_i/rf_rs2_data_i     register-file read data
//   stage_data_i                    result of entry k at [k*XLEN +: XLEN]
//   redirect_i                      taken branch/jump resolved in EX
//   mem_stall_i                     freeze the whole pipeline
//   stall_o, bubble_o, flush_o      IF/ID hold, ID/EX NOP insert, IF/ID kill
//   fwd_sel_rs1_o/fwd_sel_rs2_o     0 = register file, k+1 = entry k
//   rs1_data_o/rs2_data_o           forwarded operands
//
// Optional build macro PIPE_HAZARD_PERF_EN adds perf_stall_cnt_o (load-use
// stall cycles) and perf_flush_cnt_o (redirect cycles), both 32-bit and
// wrapping. Frozen (mem_stall_i) cycles are never counted.

module pipe_hazard_unit #(
    parameter int XLEN             = 32,
    parameter int DEPTH            = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int FWD_W            = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [4:0]            id_rs1_i,
    input  logic [4:0]            id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [4:0]            id_rd_i,
    input  logic                  id_reg_we_i,
    input  logic                  id_is_load_i,
    input  logic [XLEN-1:0]       rf_rs1_data_i,
    input  logic [XLEN-1:0]       rf_rs2_data_i,
    input  logic [DEPTH*XLEN-1:0] stage_data_i,
    input  logic                  redirect_i,
    input  logic                  mem_stall_i,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic                  flush_o,
    output logic [FWD_W-1:0]      fwd_sel_rs1_o,
    output logic [FWD_W-1:0]      fwd_sel_rs2_o,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt_o,
    output logic [31:0]           perf_flush_cnt_o
`endif
);

    // In-flight instruction tracking, one slot per stage after ID
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_load;
    logic [4:0]       r_rd [DEPTH];

    logic [DEPTH-1:0] w_hit_rs1;
    logic [DEPTH-1:0] w_hit_rs2;
    logic [FWD_W-1:0] w_sel_rs1;
    logic [FWD_W-1:0] w_sel_rs2;
    logic [XLEN-1:0]  w_data_rs1;
    logic [XLEN-1:0]  w_data_rs2;
    logic             w_lu_rs1;
    logic             w_lu_rs2;
    logic             w_load_use;
    logic             w_advance;
    logic             w_kill;

    // Per-entry source match; x0 and unread sources never match
    always_comb begin
        w_hit_rs1 = '0;
        w_hit_rs2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_hit_rs1[k] = r_valid[k] && r_we[k] && (r_rd[k] == id_rs1_i) &&
                           (id_rs1_i != 5'd0) && id_rs1_used_i;
            w_hit_rs2[k] = r_valid[k] && r_we[k] && (r_rd[k] == id_rs2_i) &&
                           (id_rs2_i != 5'd0) && id_rs2_used_i;
        end
    end

    // Youngest-wins selection: walk from the oldest entry down so the
    // lowest matching index is the last one applied
    always_comb begin
        w_sel_rs1  = '0;
        w_sel_rs2  = '0;
        w_data_rs1 = rf_rs1_data_i;
        w_data_rs2 = rf_rs2_data_i;
        w_lu_rs1   = 1'b0;
        w_lu_rs2   = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_sel_rs1  = w_hit_rs1[k] ? FWD_W'(k + 1) : w_sel_rs1;
            w_data_rs1 = w_hit_rs1[k] ? stage_data_i[k*XLEN +: XLEN] : w_data_rs1;
            w_lu_rs1   = w_hit_rs1[k] ? (r_load[k] && (k < LOAD_READY_STAGE)) : w_lu_rs1;
            w_sel_rs2  = w_hit_rs2[k] ? FWD_W'(k + 1) : w_sel_rs2;
            w_data_rs2 = w_hit_rs2[k] ? stage_data_i[k*XLEN +: XLEN] : w_data_rs2;
            w_lu_rs2   = w_hit_rs2[k] ? (r_load[k] && (k < LOAD_READY_STAGE)) : w_lu_rs2;
        end
    end

    assign w_load_use = id_valid_i && (w_lu_rs1 || w_lu_rs2);
    // Entries move whenever the pipeline is not frozen
    assign w_advance  = !mem_stall_i;
    // A redirect kills the ID instruction, so any load-use on it is moot
    assign w_kill     = redirect_i || w_load_use;

    assign stall_o       = mem_stall_i || (!redirect_i && w_load_use);
    assign bubble_o      = w_advance && w_kill;
    assign flush_o       = w_advance && redirect_i;
    assign fwd_sel_rs1_o = w_sel_rs1;
    assign fwd_sel_rs2_o = w_sel_rs2;
    assign rs1_data_o    = w_data_rs1;
    assign rs2_data_o    = w_data_rs2;

    // Tracking shift register: hold on freeze, else shift in ID or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_we    <= '0;
            r_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= 5'd0;
            end
        end else if (w_advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[0] <= w_kill ? 1'b0 : id_valid_i;
            r_we[0]    <= w_kill ? 1'b0 : id_reg_we_i;
            r_load[0]  <= w_kill ? 1'b0 : id_is_load_i;
            r_rd[0]    <= id_rd_i;
        end else begin
            r_valid <= r_valid;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Event counters for load-use stall cycles and redirect cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= 32'd0;
            r_perf_flush_cnt <= 32'd0;
        end else if (w_advance) begin
            if (redirect_i) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end else if (w_load_use) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end else begin
                r_perf_stall_cnt <= r_perf_stall_cnt;
            end
        end else begin
            r_perf_stall_cnt <= r_perf_stall_cnt;
        end
    end

    assign perf_stall_cnt_o = r_perf_stall_cnt;
    assign perf_flush_cnt_o = r_perf_flush_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule
